// File: rtl/adc_limit_monitor.sv
`default_nettype none
// ============================================================================
// Module      : adc_limit_monitor
// Description : Multi-channel ADC protection monitor. Each channel compares
//               its sample against high/low limits, debounces out-of-range
//               samples and recovers through a shared hysteresis band, either
//               automatically (non-latching) or on a clear command (latching).
//               Drives a global shutdown and captures the first channel to trip.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk                  in   system clock
//   rst_n                in   asynchronous active-low reset
//   sample_valid_i       in   all channel samples valid this cycle
//   sample_data_i        in   packed samples, channel k at [k*ADC_WIDTH +: ADC_WIDTH]
//   limit_hi_i           in   packed high limits (trip when sample > limit)
//   limit_lo_i           in   packed low limits (trip when sample < limit)
//   hyst_i               in   shared recovery hysteresis
//   ch_enable_i          in   per-channel enable, 0 forces channel idle
//   latch_mode_i         in   per-channel latching fault mode
//   fault_clear_i        in   single-cycle clear command
//   fault_active_o       out  channel is in FAULT
//   fault_sticky_o       out  channel entered FAULT since last clear
//   shutdown_o           out  OR of fault_active_o
//   first_fault_o        out  index of the first channel to trip
//   first_fault_valid_o  out  first_fault_o holds a captured index
// ============================================================================
module adc_limit_monitor #(
    parameter int NUM_CH    = 6,
    parameter int ADC_WIDTH = 12,
    parameter int DEBOUNCE  = 4,
    parameter int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_valid_i,
    input  logic [NUM_CH*ADC_WIDTH-1:0]   sample_data_i,
    input  logic [NUM_CH*ADC_WIDTH-1:0]   limit_hi_i,
    input  logic [NUM_CH*ADC_WIDTH-1:0]   limit_lo_i,
    input  logic [ADC_WIDTH-1:0]          hyst_i,
    input  logic [NUM_CH-1:0]             ch_enable_i,
    input  logic [NUM_CH-1:0]             latch_mode_i,
    input  logic                          fault_clear_i,
    output logic [NUM_CH-1:0]             fault_active_o,
    output logic [NUM_CH-1:0]             fault_sticky_o,
    output logic                          shutdown_o,
    output logic [IDX_W-1:0]              first_fault_o,
    output logic                          first_fault_valid_o
);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_PEND   = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    localparam logic [7:0] c_debounce = 8'(DEBOUNCE);

    state_t             state_q [NUM_CH];
    state_t             state_d [NUM_CH];
    logic [7:0]         cnt_q   [NUM_CH];
    logic [7:0]         cnt_d   [NUM_CH];
    logic [NUM_CH-1:0]  inband_q, inband_d;
    logic [NUM_CH-1:0]  active_q, active_d;
    logic [NUM_CH-1:0]  sticky_q, sticky_d;
    logic [NUM_CH-1:0]  w_enter;
    logic [NUM_CH-1:0]  w_oor, w_inband_now;
    logic               shutdown_q, shutdown_d;
    logic [IDX_W-1:0]   first_q, w_first_idx;
    logic               first_vld_q;

    // Per-channel comparators. The recovery thresholds are formed one bit
    // wider so the carry/borrow can drive saturation.
    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            logic [ADC_WIDTH-1:0] w_smp, w_hi, w_lo;
            logic [ADC_WIDTH:0]   w_lo_sum, w_hi_diff, w_lo_rel, w_hi_rel;

            assign w_smp     = sample_data_i[k*ADC_WIDTH +: ADC_WIDTH];
            assign w_hi      = limit_hi_i[k*ADC_WIDTH +: ADC_WIDTH];
            assign w_lo      = limit_lo_i[k*ADC_WIDTH +: ADC_WIDTH];
            assign w_lo_sum  = {1'b0, w_lo} + {1'b0, hyst_i};
            assign w_hi_diff = {1'b0, w_hi} - {1'b0, hyst_i};
            assign w_lo_rel  = w_lo_sum[ADC_WIDTH]  ? {1'b0, {ADC_WIDTH{1'b1}}} : w_lo_sum;
            assign w_hi_rel  = w_hi_diff[ADC_WIDTH] ? '0 : w_hi_diff;

            assign w_oor[k]        = sample_valid_i && ((w_smp > w_hi) || (w_smp < w_lo));
            // An inverted band (hi_rel < lo_rel) can never be satisfied.
            assign w_inband_now[k] = ({1'b0, w_smp} >= w_lo_rel) && ({1'b0, w_smp} <= w_hi_rel);
        end
    endgenerate

    always_comb begin
        inband_d = inband_q;
        active_d = '0;
        w_enter  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            if (!ch_enable_i[k]) begin
                state_d[k]  = ST_NORMAL;
                cnt_d[k]    = 8'd0;
                inband_d[k] = 1'b1;
            end else begin
                if (sample_valid_i) begin
                    inband_d[k] = w_inband_now[k];
                end
                case (state_q[k])
                    ST_NORMAL, ST_PEND: begin
                        if (w_oor[k]) begin
                            cnt_d[k]   = cnt_q[k] + 8'd1;
                            state_d[k] = ((cnt_q[k] + 8'd1) >= c_debounce) ? ST_FAULT : ST_PEND;
                        end else if (sample_valid_i) begin
                            state_d[k] = ST_NORMAL;
                            cnt_d[k]   = 8'd0;
                        end
                    end
                    ST_FAULT: begin
                        if (!latch_mode_i[k]) begin
                            if (sample_valid_i && w_inband_now[k]) begin
                                state_d[k] = ST_NORMAL;
                                cnt_d[k]   = 8'd0;
                            end
                        end else if (fault_clear_i && inband_d[k]) begin
                            // inband_d already folds in a same-cycle valid sample
                            state_d[k] = ST_NORMAL;
                            cnt_d[k]   = 8'd0;
                        end
                    end
                    default: begin
                        state_d[k] = ST_NORMAL;
                        cnt_d[k]   = 8'd0;
                    end
                endcase
            end
            active_d[k] = (state_d[k] == ST_FAULT);
            w_enter[k]  = active_d[k] && (state_q[k] != ST_FAULT);
        end
        // Set beats clear when a channel trips during the clear cycle.
        sticky_d   = (fault_clear_i ? '0 : sticky_q) | w_enter;
        shutdown_d = |active_d;
    end

    // Lowest-index channel entering FAULT this cycle.
    always_comb begin
        w_first_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_enter[k]) begin
                w_first_idx = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                state_q[k] <= ST_NORMAL;
                cnt_q[k]   <= 8'd0;
            end
            inband_q    <= '1;
            active_q    <= '0;
            sticky_q    <= '0;
            shutdown_q  <= 1'b0;
            first_q     <= '0;
            first_vld_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            inband_q   <= inband_d;
            active_q   <= active_d;
            sticky_q   <= sticky_d;
            shutdown_q <= shutdown_d;
            if (!shutdown_q && shutdown_d) begin
                first_q     <= w_first_idx;
                first_vld_q <= 1'b1;
            end else if (shutdown_q && !shutdown_d) begin
                first_q     <= '0;
                first_vld_q <= 1'b0;
            end
        end
    end

    assign fault_active_o      = active_q;
    assign fault_sticky_o      = sticky_q;
    assign shutdown_o          = shutdown_q;
    assign first_fault_o       = first_q;
    assign first_fault_valid_o = first_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_limit_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_limit_monitor
// Description : Self-checking bench for adc_limit_monitor. A behavioural model
//               tracks each channel as a consecutive-out-of-range count plus a
//               faulted flag; directed scenarios pin the model with literal
//               values and a randomized phase exercises the rest.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_limit_monitor;

    localparam int NCH = 6;
    localparam int AW  = 12;
    localparam int DEB = 4;
    localparam int IW  = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sample_valid;
    logic [NCH*AW-1:0]  sample_data, limit_hi, limit_lo;
    logic [AW-1:0]      hyst;
    logic [NCH-1:0]     ch_enable, latch_mode;
    logic               fault_clear;
    logic [NCH-1:0]     fault_active, fault_sticky;
    logic               shutdown;
    logic [IW-1:0]      first_fault;
    logic               first_fault_valid;

    adc_limit_monitor #(.NUM_CH(NCH), .ADC_WIDTH(AW), .DEBOUNCE(DEB), .IDX_W(IW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .sample_valid_i      (sample_valid),
        .sample_data_i       (sample_data),
        .limit_hi_i          (limit_hi),
        .limit_lo_i          (limit_lo),
        .hyst_i              (hyst),
        .ch_enable_i         (ch_enable),
        .latch_mode_i        (latch_mode),
        .fault_clear_i       (fault_clear),
        .fault_active_o      (fault_active),
        .fault_sticky_o      (fault_sticky),
        .shutdown_o          (shutdown),
        .first_fault_o       (first_fault),
        .first_fault_valid_o (first_fault_valid)
    );

    always #5 clk = ~clk;

    // Stimulus values per channel
    int smp [NCH];
    int lhi [NCH];
    int llo [NCH];
    int hy;

    // Behavioural model
    int       m_cnt [NCH];
    bit       m_flt [NCH];
    bit       m_inb [NCH];
    bit [5:0] m_sticky;
    bit       m_shut;
    int       m_ff;
    bit       m_ffv;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic bit [5:0] m_active();
        bit [5:0] a = '0;
        for (int k = 0; k < NCH; k++) a[k] = m_flt[k];
        return a;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_cnt[k] = 0; m_flt[k] = 0; m_inb[k] = 1;
        end
        m_sticky = '0; m_shut = 0; m_ff = 0; m_ffv = 0;
    endtask

    // One clock edge worth of the channel rules, on the currently applied inputs.
    task automatic model_update();
        bit [5:0] entered = '0;
        bit shut_old = m_shut;
        for (int k = 0; k < NCH; k++) begin
            if (!ch_enable[k]) begin
                m_flt[k] = 0; m_cnt[k] = 0; m_inb[k] = 1;
            end else begin
                int lo_rel = (llo[k] + hy > 4095) ? 4095 : llo[k] + hy;
                int hi_rel = (lhi[k] - hy < 0) ? 0 : lhi[k] - hy;
                bit oor    = sample_valid && (smp[k] > lhi[k] || smp[k] < llo[k]);
                bit inb    = (smp[k] >= lo_rel) && (smp[k] <= hi_rel);
                bit inb_ef = sample_valid ? inb : m_inb[k];
                if (m_flt[k]) begin
                    if (!latch_mode[k] ? (sample_valid && inb) : (fault_clear && inb_ef)) begin
                        m_flt[k] = 0; m_cnt[k] = 0;
                    end
                end else if (sample_valid) begin
                    if (oor) begin
                        m_cnt[k]++;
                        if (m_cnt[k] >= DEB) begin
                            m_flt[k] = 1; entered[k] = 1;
                        end
                    end else begin
                        m_cnt[k] = 0;
                    end
                end
                m_inb[k] = inb_ef;
            end
        end
        m_sticky = (fault_clear ? 6'b0 : m_sticky) | entered;
        m_shut   = |m_active();
        if (!shut_old && m_shut) begin
            m_ffv = 1;
            for (int k = NCH - 1; k >= 0; k--) if (entered[k]) m_ff = k;
        end else if (shut_old && !m_shut) begin
            m_ffv = 0; m_ff = 0;
        end
    endtask

    task automatic pack();
        for (int k = 0; k < NCH; k++) begin
            sample_data[k*AW +: AW] = AW'(smp[k]);
            limit_hi[k*AW +: AW]    = AW'(lhi[k]);
            limit_lo[k*AW +: AW]    = AW'(llo[k]);
        end
        hyst = AW'(hy);
    endtask

    // Apply inputs, clock once, advance the model; returns 1 time unit after the edge.
    task automatic step(input bit v, input bit clr);
        sample_valid = v;
        fault_clear  = clr;
        pack();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Compare process: model vs DUT on every falling edge outside reset
    always @(negedge clk) begin
        if (rst_n) begin
            chk("fault_active", 32'(fault_active), 32'(m_active()));
            chk("fault_sticky", 32'(fault_sticky), 32'(m_sticky));
            chk("shutdown", 32'(shutdown), 32'(m_shut));
            chk("first_fault", 32'(first_fault), 32'(m_ff));
            chk("first_fault_valid", 32'(first_fault_valid), 32'(m_ffv));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        sample_valid = 1'b0;
        fault_clear = 1'b0;
        ch_enable = 6'b111111;
        latch_mode = 6'b000000;
        hy = 100;
        for (int k = 0; k < NCH; k++) begin
            smp[k] = 2000; lhi[k] = 4000; llo[k] = 100;
        end
        pack();
        model_reset();
        #23;
        chk("reset_active", 32'(fault_active), 32'h0);
        chk("reset_shutdown", 32'(shutdown), 32'h0);
        chk("reset_ffv", 32'(first_fault_valid), 32'h0);
        rst_n = 1'b1;

        // Trip timing on ch2
        smp[2] = 4095;
        for (int i = 0; i < 3; i++) step(1, 0);
        chk("trip_pre", 32'(fault_active), 32'h0);
        step(1, 0);
        chk("trip_active", 32'(fault_active), 32'h04);
        chk("trip_shutdown", 32'(shutdown), 32'h1);
        chk("trip_ff", 32'(first_fault), 32'h2);
        chk("trip_ffv", 32'(first_fault_valid), 32'h1);

        // Non-latching hysteresis
        smp[2] = 3950; step(1, 0);
        chk("hyst_hold", 32'(fault_active), 32'h04);
        smp[2] = 3900; step(1, 0);
        chk("hyst_rec", 32'(fault_active), 32'h0);
        chk("hyst_shutdown", 32'(shutdown), 32'h0);
        chk("hyst_ffv", 32'(first_fault_valid), 32'h0);
        chk("hyst_sticky", 32'(fault_sticky), 32'h04);
        step(0, 1);
        chk("clear_sticky", 32'(fault_sticky), 32'h0);

        // Debounce reset
        smp[2] = 4095; for (int i = 0; i < 3; i++) step(1, 0);
        smp[2] = 3000; step(1, 0);
        smp[2] = 4095; for (int i = 0; i < 3; i++) step(1, 0);
        chk("deb_nofault", 32'(fault_active), 32'h0);
        step(1, 0);
        chk("deb_fault", 32'(fault_active), 32'h04);
        smp[2] = 2000; step(1, 0);
        step(0, 1);

        // Latching on ch5
        latch_mode[5] = 1'b1; llo[5] = 500; smp[5] = 200;
        for (int i = 0; i < 4; i++) step(1, 0);
        chk("latch_trip", 32'(fault_active), 32'h20);
        chk("latch_ff", 32'(first_fault), 32'h5);
        smp[5] = 450; step(1, 1);
        chk("latch_hold", 32'(fault_active), 32'h20);
        chk("latch_sticky_clr", 32'(fault_sticky[5]), 32'h0);
        smp[5] = 700; step(1, 0);
        chk("latch_no_autorec", 32'(fault_active), 32'h20);
        step(0, 1);
        chk("latch_rec", 32'(fault_active), 32'h0);
        latch_mode[5] = 1'b0; llo[5] = 100; smp[5] = 2000;

        // Simultaneous trip ch1 and ch4
        smp[1] = 4095; smp[4] = 4095;
        for (int i = 0; i < 4; i++) step(1, 0);
        chk("sim_active", 32'(fault_active), 32'h12);
        chk("sim_ff", 32'(first_fault), 32'h1);
        smp[1] = 2000; step(1, 0);
        chk("sim_keep_active", 32'(fault_active), 32'h10);
        chk("sim_keep_ff", 32'(first_fault), 32'h1);
        chk("sim_keep_shutdown", 32'(shutdown), 32'h1);
        smp[4] = 2000; step(1, 0);
        step(0, 1);

        // Asynchronous reset with ch3 faulted and ch2 pending
        smp[3] = 4095;
        step(1, 0); step(1, 0);
        smp[2] = 4095;
        step(1, 0); step(1, 0);
        chk("pre_rst_active", 32'(fault_active), 32'h08);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_active", 32'(fault_active), 32'h0);
        chk("arst_sticky", 32'(fault_sticky), 32'h0);
        chk("arst_shutdown", 32'(shutdown), 32'h0);
        chk("arst_ffv", 32'(first_fault_valid), 32'h0);
        smp[3] = 2000;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 0);
        chk("post_rst_notrip", 32'(fault_active), 32'h0);
        step(1, 0);
        chk("post_rst_trip", 32'(fault_active), 32'h04);
        ch_enable[2] = 1'b0; step(1, 0);
        chk("disable_clear", 32'(fault_active), 32'h0);
        ch_enable[2] = 1'b1; smp[2] = 2000; step(1, 1);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                for (int k = 0; k < NCH; k++) begin
                    llo[k] = $urandom_range(0, 1500);
                    lhi[k] = $urandom_range(2500, 4095);
                end
            end
            if ($urandom_range(0, 79) == 0) hy = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 300);
            if ($urandom_range(0, 99) == 0) latch_mode = 6'($urandom);
            if ($urandom_range(0, 199) == 0) ch_enable[$urandom_range(0, NCH-1)] ^= 1'b1;
            for (int k = 0; k < NCH; k++) begin
                int v;
                case ($urandom_range(0, 3))
                    0:       v = $urandom_range(0, 4095);
                    1:       v = lhi[k] + $urandom_range(0, 300) - 150;
                    2:       v = llo[k] + $urandom_range(0, 300) - 150;
                    default: v = smp[k];
                endcase
                smp[k] = (v < 0) ? 0 : (v > 4095) ? 4095 : v;
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
